// File: rtl/clock_mode_controller.sv
// Digital clock mode sequencer: CLOCK / time adjust / alarm adjust.
// Optional alarm fields enabled by defining ALARM_ADJUST_EN.
module clock_mode_controller #(
  parameter int unsigned TIMEOUT_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_center,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       enable_seconds,
  output logic       adjust_enable_minutes,
  output logic       adjust_enable_hours,
  output logic       alarm_adjust_minutes,
  output logic       alarm_adjust_hours,
  output logic       Up_down,
  output logic [2:0] mode,
  output logic       adjust_active,
  output logic       blink
);

  typedef enum logic [2:0] {
    S_CLOCK = 3'd0,
    S_HOUR  = 3'd1,
    S_MIN   = 3'd2,
    S_AHOUR = 3'd3,
    S_AMIN  = 3'd4
  } state_e;

  localparam logic [5:0] TO = 6'(TIMEOUT_TICKS);

  state_e     state_q, state_d;
  state_e     nxt, prv;
  logic [5:0] cnt_q, cnt_d;
  logic       ud_q, ud_d;
  logic       blink_q, blink_d;
  logic       act_q, act_d;
  logic       es_q, es_d;
  logic       aem_q, aem_d;
  logic       aeh_q, aeh_d;
  logic       lr_ev, ud_ev;

  assign lr_ev = btn_left ^ btn_right;
  assign ud_ev = btn_up ^ btn_down;

`ifdef ALARM_ADJUST_EN
  logic aam_q, aam_d;
  logic aah_q, aah_d;

  always_comb begin
    nxt = S_HOUR;
    prv = S_HOUR;
    case (state_q)
      S_HOUR:  begin nxt = S_MIN;   prv = S_AMIN;  end
      S_MIN:   begin nxt = S_AHOUR; prv = S_HOUR;  end
      S_AHOUR: begin nxt = S_AMIN;  prv = S_MIN;   end
      S_AMIN:  begin nxt = S_HOUR;  prv = S_AHOUR; end
      default: begin nxt = S_HOUR;  prv = S_HOUR;  end
    endcase
  end
`else
  // Two fields only: left and right both toggle.
  always_comb begin
    nxt = (state_q == S_HOUR) ? S_MIN : S_HOUR;
    prv = nxt;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ud_d    = ud_q;
    blink_d = blink_q;
    es_d    = 1'b0;
    aem_d   = 1'b0;
    aeh_d   = 1'b0;
`ifdef ALARM_ADJUST_EN
    aam_d   = 1'b0;
    aah_d   = 1'b0;
`endif
    if (state_q == S_CLOCK) begin
      es_d = tick_1hz;
      if (btn_center) state_d = S_HOUR;
    end else begin
      if (cnt_q == TO) begin
        state_d = S_CLOCK;
      end else if (btn_center) begin
        state_d = S_CLOCK;
      end else if (lr_ev) begin
        state_d = btn_right ? nxt : prv;
      end else if (ud_ev) begin
        cnt_d = '0;
        ud_d  = btn_up;
        case (state_q)
          S_HOUR:  aeh_d = 1'b1;
          S_MIN:   aem_d = 1'b1;
`ifdef ALARM_ADJUST_EN
          S_AHOUR: aah_d = 1'b1;
          S_AMIN:  aam_d = 1'b1;
`endif
          default: ;
        endcase
      end else if (tick_1hz) begin
        cnt_d = cnt_q + 6'd1;
      end
      if (tick_1hz) blink_d = ~blink_q;
    end
    if (state_d != state_q) begin
      cnt_d   = '0;
      blink_d = 1'b0;
    end
    if (state_d == S_CLOCK) begin
      ud_d    = 1'b1;
      blink_d = 1'b0;
    end
    act_d = (state_d != S_CLOCK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLOCK;
      cnt_q   <= '0;
      ud_q    <= 1'b1;
      blink_q <= 1'b0;
      act_q   <= 1'b0;
      es_q    <= 1'b0;
      aem_q   <= 1'b0;
      aeh_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ud_q    <= ud_d;
      blink_q <= blink_d;
      act_q   <= act_d;
      es_q    <= es_d;
      aem_q   <= aem_d;
      aeh_q   <= aeh_d;
    end
  end

`ifdef ALARM_ADJUST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aam_q <= 1'b0;
      aah_q <= 1'b0;
    end else begin
      aam_q <= aam_d;
      aah_q <= aah_d;
    end
  end

  assign alarm_adjust_minutes = aam_q;
  assign alarm_adjust_hours   = aah_q;
`else
  assign alarm_adjust_minutes = 1'b0;
  assign alarm_adjust_hours   = 1'b0;
`endif

  assign enable_seconds        = es_q;
  assign adjust_enable_minutes = aem_q;
  assign adjust_enable_hours   = aeh_q;
  assign Up_down               = ud_q;
  assign mode                  = state_q;
  assign adjust_active         = act_q;
  assign blink                 = blink_q;

endmodule
